// File: rtl/int_to_fp.sv
// rtl/int_to_fp.sv - pipelined signed fixed-point integer to sign/exponent/mantissa float converter
// Stages: magnitude, leading-zero count, 2-bit-per-stage normalizer, then RNE rounding into the output register.
module int_to_fp #(
    parameter int INT_SIZE             = 25,
    parameter int EXPONENT_SIZE        = 8,
    parameter int MANTISSA_SIZE        = 7,
    parameter int FIXED_POINT_POSITION = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [INT_SIZE-1:0]      din,
    input  logic                     din_valid,
    output logic                     sign,
    output logic [EXPONENT_SIZE-1:0] exponent,
    output logic [MANTISSA_SIZE-1:0] mantissa,
    output logic                     dout_valid
);

    localparam int LOG_SIZE        = $clog2(INT_SIZE);
    localparam int SHIFTER_LATENCY = (LOG_SIZE + 1) / 2;
    localparam int LZW             = 2 * SHIFTER_LATENCY;
    localparam int NW              = INT_SIZE + MANTISSA_SIZE + 2;
    localparam int EBASE           = 127 + INT_SIZE - 1 - FIXED_POINT_POSITION;

    logic                     r_s1_sign, r_s1_valid;
    logic [INT_SIZE-1:0]      r_s1_mag;
    logic                     r_s2_sign, r_s2_valid, r_s2_zero;
    logic [INT_SIZE-1:0]      r_s2_mag;
    logic [LZW-1:0]           r_s2_lz;
    logic [INT_SIZE-1:0]      r_sh_data [SHIFTER_LATENCY];
    logic [LZW-1:0]           r_sh_lz   [SHIFTER_LATENCY];
    logic [SHIFTER_LATENCY-1:0] r_sh_sign, r_sh_zero, r_sh_valid;
    logic                     r_sign, r_valid;
    logic [EXPONENT_SIZE-1:0] r_exp;
    logic [MANTISSA_SIZE-1:0] r_mant;

    logic [INT_SIZE-1:0]      w_mag;
    logic [LZW-1:0]           w_lz;
    logic                     w_found;
    logic [NW-1:0]            w_ext;
    logic [MANTISSA_SIZE-1:0] w_frac;
    logic                     w_guard, w_sticky, w_round;
    logic [MANTISSA_SIZE:0]   w_sum;
    logic [EXPONENT_SIZE-1:0] w_exp;

    // Unary minus of the most negative input yields 2^(INT_SIZE-1), which fits unsigned.
    assign w_mag = din[INT_SIZE-1] ? -din : din;

    always_comb begin
        w_lz    = '0;
        w_found = 1'b0;
        for (int i = INT_SIZE - 1; i >= 0; i--) begin
            if (!w_found && r_s1_mag[i]) begin
                w_lz    = LZW'(INT_SIZE - 1 - i);
                w_found = 1'b1;
            end
        end
    end

    // Padding below the normalized value gives zero-fill for short magnitudes and a guard bit always.
    always_comb begin
        w_ext    = {r_sh_data[SHIFTER_LATENCY-1], {(MANTISSA_SIZE + 2){1'b0}}};
        w_frac   = w_ext[NW-2 -: MANTISSA_SIZE];
        w_guard  = w_ext[NW-2-MANTISSA_SIZE];
        w_sticky = |w_ext[NW-3-MANTISSA_SIZE:0];
        w_round  = w_guard & (w_sticky | w_frac[0]);
        w_sum    = {1'b0, w_frac} + {{MANTISSA_SIZE{1'b0}}, w_round};
        w_exp    = EXPONENT_SIZE'(EBASE) - EXPONENT_SIZE'(r_sh_lz[SHIFTER_LATENCY-1])
                 + EXPONENT_SIZE'(w_sum[MANTISSA_SIZE]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_sign  <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_mag   <= '0;
            r_s2_sign  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_mag   <= '0;
            r_s2_lz    <= '0;
            for (int k = 0; k < SHIFTER_LATENCY; k++) begin
                r_sh_data[k] <= '0;
                r_sh_lz[k]   <= '0;
            end
            r_sh_sign  <= '0;
            r_sh_zero  <= '0;
            r_sh_valid <= '0;
            r_sign     <= 1'b0;
            r_valid    <= 1'b0;
            r_exp      <= '0;
            r_mant     <= '0;
        end else if (ena) begin
            r_s1_sign  <= din[INT_SIZE-1];
            r_s1_valid <= din_valid;
            r_s1_mag   <= w_mag;

            r_s2_sign  <= r_s1_sign;
            r_s2_valid <= r_s1_valid;
            r_s2_zero  <= ~|r_s1_mag;
            r_s2_mag   <= r_s1_mag;
            r_s2_lz    <= w_lz;

            // Stage k applies lz bits [2k+1:2k]; masking keeps the shift amount at full width.
            r_sh_data[0]  <= r_s2_mag << (r_s2_lz & LZW'(3));
            r_sh_lz[0]    <= r_s2_lz;
            r_sh_sign[0]  <= r_s2_sign;
            r_sh_zero[0]  <= r_s2_zero;
            r_sh_valid[0] <= r_s2_valid;
            for (int k = 1; k < SHIFTER_LATENCY; k++) begin
                r_sh_data[k]  <= r_sh_data[k-1] << (r_sh_lz[k-1] & (LZW'(3) << (2 * k)));
                r_sh_lz[k]    <= r_sh_lz[k-1];
                r_sh_sign[k]  <= r_sh_sign[k-1];
                r_sh_zero[k]  <= r_sh_zero[k-1];
                r_sh_valid[k] <= r_sh_valid[k-1];
            end

            r_valid <= r_sh_valid[SHIFTER_LATENCY-1];
            if (r_sh_zero[SHIFTER_LATENCY-1]) begin
                r_sign <= 1'b0;
                r_exp  <= '0;
                r_mant <= '0;
            end else begin
                r_sign <= r_sh_sign[SHIFTER_LATENCY-1];
                r_exp  <= w_exp;
                r_mant <= w_sum[MANTISSA_SIZE-1:0];
            end
        end
    end

    assign sign       = r_sign;
    assign exponent   = r_exp;
    assign mantissa   = r_mant;
    assign dout_valid = r_valid;

endmodule
